// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full adder (two half-adder cells + OR) iterated LSB first.
// Latency: start accepted at edge 0, done pulses in the cycle after edge N.
// Backpressure: start is ignored while busy; result holds until the next accepted start.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [N-1:0]   ra;
    logic [N-1:0]   rb;
    logic           c;
    logic [CW-1:0]  cnt;

    logic           s0;
    logic           c0;
    logic           bit_s;
    logic           c1;
    logic           carry_nxt;
    logic [N-1:0]   sum_nxt;

    half_adder u_ha0 (.x(ra[0]), .y(rb[0]), .s(s0),    .c(c0));
    half_adder u_ha1 (.x(s0),    .y(c),     .s(bit_s), .c(c1));

    assign carry_nxt = c0 | c1;

    // New bit enters at the MSB so after N shifts the LSB-first bits line up.
    if (N == 1) begin : g_sum_n1
        assign sum_nxt = bit_s;
    end else begin : g_sum_nw
        assign sum_nxt = {bit_s, sum[N-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ra    <= '0;
            rb    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        c     <= cin;
                        sum   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    c   <= carry_nxt;
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    sum <= sum_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        cout  <= carry_nxt;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: N=4 instance plus an N=1 instance checked exhaustively.
// Expected sums come from a queue filled as operands are driven and drained on each done.

module tb_serial_adder;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a     = '0;
    logic [N-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    logic         start1 = 1'b0;
    logic [0:0]   a1     = '0;
    logic [0:0]   b1     = '0;
    logic         cin1   = 1'b0;
    logic         busy1;
    logic         done1;
    logic [0:0]   sum1;
    logic         cout1;

    serial_adder #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;

    logic [N:0] q[$];
    logic [1:0] q1[$];

    always @(negedge clk) if (done) n_done++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_add(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tc);
        logic [N:0] e;
        a     = ta;
        b     = tb_v;
        cin   = tc;
        start = 1'b1;
        e = {1'b0, ta} + {1'b0, tb_v} + {{N{1'b0}}, tc};
        q.push_back(e);
        tick();
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic wait_done(input string tag, output int lat);
        logic [N:0] e;
        logic       found;
        found = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (done === 1'b1) begin
                found = 1'b1;
                lat   = i;
            end
        end
        check({tag, "_done_seen"}, 32'(found), 32'd1);
        if (found && q.size() > 0) begin
            e = q.pop_front();
            check({tag, "_result"}, 32'({cout, sum}), 32'(e));
        end
    endtask

    task automatic wait_done1(input string tag);
        logic [1:0] e;
        logic       found;
        int         lat;
        found = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 10 && !found; i++) begin
            tick();
            if (done1 === 1'b1) begin
                found = 1'b1;
                lat   = i;
            end
        end
        check({tag, "_done_seen"}, 32'(found), 32'd1);
        if (found && q1.size() > 0) begin
            e = q1.pop_front();
            check({tag, "_result"}, 32'({cout1, sum1}), 32'(e));
            check({tag, "_latency"}, 32'(lat), 32'd1);
        end
    endtask

    initial begin
        int lat;
        int d0;

        // asynchronous reset, checked before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // basic add with latency and hold
        do_add(4'd3, 4'd5, 1'b0);
        check("basic_busy_run", 32'(busy), 32'd1);
        wait_done("basic", lat);
        check("basic_latency", 32'(lat), 32'(N));
        check("basic_busy_done", 32'(busy), 32'd1);
        tick();
        check("basic_done_pulse", 32'(done), 32'd0);
        check("basic_busy_idle", 32'(busy), 32'd0);
        tick();
        tick();
        tick();
        check("basic_hold_sum", 32'(sum), 32'd8);
        check("basic_hold_cout", 32'(cout), 32'd0);

        // carry chain
        do_add(4'd15, 4'd1, 1'b0);
        wait_done("carry_15_1", lat);
        tick();
        do_add(4'd15, 4'd15, 1'b1);
        wait_done("carry_15_15_1", lat);
        tick();
        do_add(4'd0, 4'd0, 1'b1);
        wait_done("carry_0_0_1", lat);
        tick();

        // start while busy is ignored
        d0 = n_done;
        do_add(4'd2, 4'd2, 1'b0);
        tick();
        tick();
        a     = 4'd7;
        b     = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_start", lat);
        tick();
        check("busy_start_one_done", 32'(n_done - d0), 32'd1);
        check("busy_start_no_rerun", 32'(busy), 32'd0);

        // reset mid-operation
        d0 = n_done;
        do_add(4'd9, 4'd6, 1'b0);
        void'(q.pop_back());
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum",  32'(sum),  32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        tick();
        tick();
        tick();
        check("midrst_no_done", 32'(n_done - d0), 32'd0);
        rst_n = 1'b1;
        do_add(4'd1, 4'd1, 1'b0);
        wait_done("after_rst", lat);
        check("after_rst_latency", 32'(lat), 32'(N));
        tick();

        // back-to-back with start held high: one add every N+2 cycles
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [N:0] e;
            a   = N'($urandom);
            b   = N'($urandom);
            cin = 1'($urandom);
            e = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
            q.push_back(e);
            tick();
            a   = N'($urandom);
            b   = N'($urandom);
            cin = 1'($urandom);
            wait_done($sformatf("b2b%0d", k), lat);
            check($sformatf("b2b%0d_latency", k), 32'(lat), 32'(N));
            tick();
            check($sformatf("b2b%0d_idle", k), 32'(busy), 32'd0);
        end
        start = 1'b0;
        tick();

        // exhaustive N=1
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] e;
            v      = 3'(i);
            a1     = v[2];
            b1     = v[1];
            cin1   = v[0];
            start1 = 1'b1;
            e = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
            q1.push_back(e);
            tick();
            start1 = 1'b0;
            wait_done1($sformatf("n1_case%0d", i));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built as the sequential stage around the team's half-adder cell.
- Per cycle: two half-adder cells plus an OR form a full adder; a carry flip-flop and shift registers then process one operand bit, LSB first.
- Parallel operands in, parallel sum/carry out, start/busy/done handshake.
- Trades N cycles of latency for one full-adder of logic.

Parameters:
- N, 4, operand/sum width in bits; legal range N >= 1.

Ports:
- clk    input   1  rising-edge clock
- rst_n  input   1  reset, asynchronous, active-low
- start  input   1  request; sampled only in IDLE
- a      input   N  operand A; captured on accepted start
- b      input   N  operand B; captured on accepted start
- cin    input   1  carry-in; captured on accepted start
- busy   output  1  high in RUN and DONE
- done   output  1  one-cycle pulse; result valid
- sum    output  N  result register
- cout   output  1  final carry-out

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values (rst_n=0, immediate, no clock needed):
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry FF and bit counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture a->ra, b->rb, cin->c; clear sum register and counter; go RUN.
  - start=0: stay; sum/cout hold the previous result.
- RUN, at each edge:
  - bit = ra[0]^rb[0]^c.
  - c <= (ra[0]&rb[0]) | (c&(ra[0]^rb[0])), i.e. the two half-adder carries ORed.
  - ra, rb shift right by 1.
  - sum shifts right by 1 with bit inserted at sum[N-1].
  - counter increments.
  - On the edge where counter == N-1, the final bit is processed, cout <= carry-out of that bit, and the FSM goes DONE.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE unconditionally.
- Latency: start accepted at edge 0 -> RUN edges 1..N -> done high in the cycle after edge N. Total N+1 edges from start to done.
- Result: sum and cout equal (a+b+cin) mod 2^N and its carry. They stay stable from done until the next accepted start.
- During RUN, sum shows partial shifted contents and must not be used.
- Width rule: the result is exactly N+1 bits ({cout,sum}); there is no overflow beyond cout.
- Boundary conditions:
  - start while busy=1 (RUN or DONE): ignored; operands are not re-captured.
  - start held high continuously: a new operation begins at the first edge in IDLE, giving a period of N+2 cycles per add.
  - a, b, cin changing after capture: no effect on the result.
  - rst_n low mid-RUN: immediate abort to reset values; no done pulse.
  - rst_n released: first start is sampled at the first rising edge with rst_n=1.
  - N=1: RUN lasts one edge, then DONE.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, N=4: rst_n=0 with no clock -> busy=0, done=0, sum=0, cout=0 immediately.
- Basic add, N=4: a=3, b=5, cin=0, start pulse -> busy=1 for 5 cycles; done pulse 5 edges after start; sum=8, cout=0; values held until the next start.
- Carry chain, N=4: a=15, b=1, cin=0 -> sum=0, cout=1.
  - a=15, b=15, cin=1 -> sum=15, cout=1.
  - a=0, b=0, cin=1 -> sum=1, cout=0.
- Start while busy: a=2, b=2, then start again at RUN cycle 2 with a=7, b=7 -> second start ignored; exactly one done; sum=4, cout=0.
- Reset mid-op: a=9, b=6, start; rst_n=0 at RUN cycle 2 -> outputs cleared; no done pulse.
  - Then a=1, b=1 -> sum=2, done after N+1 edges.
- Back-to-back and N=1: start held high with changing operands -> one done every 6 cycles; each result matches its captured operands.
  - Exhaustive check at N=1 (a, b, cin over all 8 cases) -> {cout,sum} = a+b+cin.
